// File: rtl/fetch_redirect_ctrl.sv
// Redirect side of the fetch PC interface: arbitrates exception, execute-branch and
// decode-JAL redirects, implements halt, and marks wrong-path fetch slots.
//
// state | meaning
// RUN   | normal fetch; JAL decode and halt entry enabled
// FLUSH | one wrong-path slot after a redirect; only exc/ex honoured
// HALT  | fetch pinned to the held PC until halt_req drops
module fetch_redirect_ctrl #(
    parameter logic [31:0] EXC_VEC = 32'h0000_0100,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             exc_req,
    input  logic             halt_req,
    output logic             pc_update,
    output logic [31:0]      pc_new,
    output logic             fetch_valid,
    output logic             flush,
    output logic             misalign_err,
    output logic [31:0]      epc,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [6:0] JAL_OP = 7'b1101111;

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] held_pc;
    logic [31:0] jal_imm;
    logic [31:0] jal_target;
    logic [31:0] raw_target;
    logic        is_jal;
    logic        redirect;
    logic        check_align;
    logic        take_epc;
    logic        latch_held;
    logic        count_inc;

    assign is_jal     = (instr[6:0] == JAL_OP);
    assign jal_imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign jal_target = pc + jal_imm;
    assign halted     = (state == HALT);

    always_comb begin
        state_nxt    = state;
        pc_update    = 1'b0;
        pc_new       = 32'h0;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        misalign_err = 1'b0;
        redirect     = 1'b0;
        check_align  = 1'b0;
        take_epc     = 1'b0;
        latch_held   = 1'b0;
        count_inc    = 1'b0;
        raw_target   = 32'h0;

        case (state)
            RUN: begin
                fetch_valid = !exc_req && !ex_redirect;
                if (fetch_valid && is_jal) begin
                    redirect    = 1'b1;
                    raw_target  = jal_target;
                    check_align = 1'b1;
                    state_nxt   = FLUSH;
                end else if (fetch_valid && halt_req) begin
                    // Re-fetch the current instruction after release, so it is not consumed now
                    pc_update   = 1'b1;
                    pc_new      = pc;
                    flush       = 1'b1;
                    fetch_valid = 1'b0;
                    latch_held  = 1'b1;
                    count_inc   = 1'b1;
                    state_nxt   = HALT;
                end
            end
            FLUSH: state_nxt = RUN;
            HALT: begin
                if (halt_req) begin
                    pc_update = 1'b1;
                    pc_new    = held_pc;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        // exc/ex are honoured in every state and override whatever the state chose
        if (exc_req) begin
            redirect    = 1'b1;
            raw_target  = EXC_VEC;
            check_align = 1'b0;
            take_epc    = 1'b1;
            latch_held  = 1'b0;
            state_nxt   = FLUSH;
        end else if (ex_redirect) begin
            redirect    = 1'b1;
            raw_target  = ex_target;
            check_align = 1'b1;
            latch_held  = 1'b0;
            state_nxt   = FLUSH;
        end

        if (redirect) begin
            pc_update = 1'b1;
            flush     = 1'b1;
            count_inc = 1'b1;
            if (check_align && (raw_target[1:0] != 2'b00)) begin
                pc_new       = EXC_VEC;
                misalign_err = 1'b1;
                take_epc     = 1'b1;
            end else begin
                pc_new = raw_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            held_pc        <= 32'h0;
            epc            <= 32'h0;
            redirect_count <= '0;
        end else begin
            state <= state_nxt;
            if (latch_held)
                held_pc <= pc;
            if (take_epc)
                epc <= pc;
            if (count_inc && (redirect_count != {CNT_W{1'b1}}))
                redirect_count <= redirect_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Drives the instruction fetch unit's `pc_update`/`pc_new` inputs. It is the redirect side of the fetch PC interface.
- Watches the fetched `pc`/`instr` stream and arbitrates three redirect sources: exception, execute-stage branch, decode-stage JAL. It also implements halt.
- Squashes wrong-path fetch slots caused by the fetch unit's two-stage PC latency. Downstream decode consumes an instruction only when `fetch_valid`=1.

Parameters:
- `EXC_VEC`, 32'h0000_0100, exception/misalignment target address.
- `CNT_W`, 16, width of the saturating redirect counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `pc`  in  32  fetch unit PC output (address of `instr`)
- `instr`  in  32  instruction word at `pc` (combinational imem read)
- `ex_redirect`  in  1  execute-stage taken branch/mispredict, single cycle
- `ex_target`  in  32  execute-stage target, valid with `ex_redirect`
- `exc_req`  in  1  exception request, single cycle
- `halt_req`  in  1  level; hold fetch while high
- `pc_update`  out  1  redirect strobe to fetch unit (combinational)
- `pc_new`  out  32  redirect target (combinational)
- `fetch_valid`  out  1  current `pc`/`instr` is on the correct path
- `flush`  out  1  high in the redirect cycle; kills the downstream decode slot
- `misalign_err`  out  1  one-cycle pulse: a redirect target had [1:0]!=0
- `epc`  out  32  registered PC of the instruction in decode at the last exception
- `halted`  out  1  state==HALT
- `redirect_count`  out  CNT_W  saturating count of redirects issued

Behaviour:
- Reset (`reset`=0, async): state=RUN, `epc`=0, `redirect_count`=0.
  - While in reset all outputs are 0 except `fetch_valid`=1 (state RUN, no request).
- Fetch timing: `pc_update` sampled at edge N appears on `pc` in cycle N+2. Cycle N+1 carries one wrong-path slot.
- States: RUN, FLUSH, HALT (registered). All outputs other than `epc`/`redirect_count` are Mealy, derived from state and current inputs.
- JAL decode: active only when `fetch_valid`=1 and `instr[6:0]`=7'b1101111.
  - Target = `pc` + sext({i[31],i[19:12],i[20],i[30:21],1'b0}), 32-bit wrap-around.
- Priority (highest first): `exc_req` > `ex_redirect` > JAL > `halt_req` entry.
  - exc: target=`EXC_VEC`; `epc`<=`pc` at the clock edge.
  - ex: target=`ex_target`.
  - JAL: target=JAL target.
  - halt entry (RUN only): target=`pc`, i.e. the current instruction is not consumed.
- Misaligned target (bits [1:0]!=0, ex or JAL only): `pc_new`=`EXC_VEC`, `misalign_err`=1, `epc`<=`pc`.
- RUN:
  - `fetch_valid` = !`exc_req` && !`ex_redirect`. The JAL instruction itself is valid; slots killed by ex/exc are not.
  - Any redirect: `pc_update`=1, `flush`=1, next state=FLUSH. Halt entry goes to HALT instead.
- FLUSH (exactly 1 cycle):
  - `fetch_valid`=0; JAL decode and `halt_req` are ignored.
  - `exc_req`/`ex_redirect` are honoured (new redirect, stay FLUSH). Otherwise next state=RUN.
- HALT:
  - `fetch_valid`=0. `pc_update`=1 with `pc_new`=held PC (latched at entry) every cycle.
  - `halt_req`=0: `pc_update`=0, next state=RUN. The held PC appears valid next cycle.
  - `exc_req`/`ex_redirect` in HALT: redirect, next state=FLUSH. Halt is re-evaluated from RUN.
- `redirect_count`:
  - +1 per cycle with `pc_update`=1, excluding HALT hold cycles (halt entry counts once).
  - Saturates at 2^CNT_W-1, no wrap.
- Simultaneous exc+ex+JAL: only exc is acted on; ex and JAL are dropped and the JAL slot is invalid.
- `reset` asserted mid-FLUSH or mid-HALT: returns immediately to RUN. Any held PC is discarded.

Test Plan:
- Reset release, plain stream: `pc` 0,4,8,... -> `fetch_valid`=1 every cycle, `pc_update`=0, count=0.
- JAL at `pc`=0x10 with imm=+0x40 -> `pc_update`=1, `pc_new`=0x50 that cycle, `fetch_valid`=1 for 0x10. Next cycle `pc`=0x14: `fetch_valid`=0. Then `pc`=0x50: `fetch_valid`=1, count=1.
- `ex_redirect` with `ex_target`=0x200 in the same cycle as JAL at 0x20 -> `pc_new`=0x200, JAL ignored, `fetch_valid`=0 for 0x20 and the following slot.
- `exc_req` with `ex_redirect` at `pc`=0x34 -> `pc_new`=0x100, `epc`=0x34. Then `ex_target`=0x202 in RUN -> `pc_new`=0x100, `misalign_err` pulse.
- `halt_req` high 5 cycles at `pc`=0x80 -> `pc_update`=1 every cycle with `pc_new`=0x80, `halted`=1, count +1 only. After release, `pc`=0x80 with `fetch_valid`=1, then 0x84.
- Force count to max via 65535 JALs, then one more -> stays 0xFFFF. Assert `reset` in HALT -> `halted`=0 immediately, count=0.
